led_pwm_driver: RTL and testbench

Multi-channel LED/indicator PWM driver: the output-side counterpart of the switch debouncer, sitting between the control logic and the board's LED pins. Each channel's brightness is set through a valid/ready write port. Writes are buffered in per-channel shadow registers and committed only at a PWM period boundary, so a duty change never produces a truncated or glitched pulse. A shared prescaler sets the PWM step rate.

---
 rtl/led_pwm_driver_pkg.sv | 10 +
 rtl/led_pwm_driver_tick_divider.sv | 27 ++
 rtl/led_pwm_driver.sv | 112 +++++++++++
 tb/tb_led_pwm_driver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_driver_pkg.sv
// Shared helpers for the LED PWM driver slice: index-width derivation used on
// the write-port channel select.
package led_pwm_driver_pkg;

  // A one-entry table still needs a one-bit select so the port never collapses.
  function automatic int index_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_driver_tick_divider.sv
// Free-running divider: one-clk tick every TICKS cycles. Also serves as the
// sample-rate source for the switch debouncer.
module tick_divider #(
  parameter int TICKS = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  logic [31:0] count;

  assign tick = (count == 32'(TICKS - 1));

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel PWM driver: duty writes land in per-channel shadow registers
// and become active only at a period boundary, so pulses are never truncated.
module led_pwm_driver
  import led_pwm_driver_pkg::*;
#(
  parameter  int WIDTH          = 2,
  parameter  int DUTY_BITS      = 8,
  parameter  int TICKS_PER_STEP = 1000,
  localparam int CH_BITS        = index_bits(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CH_BITS-1:0]   wr_channel,
  input  logic [DUTY_BITS-1:0] wr_duty,
  output logic [WIDTH-1:0]     out,
  output logic                 period_start
);

  // Last phase value before the wrap; the period is 2^DUTY_BITS-1 steps so
  // that the all-ones duty means constantly on.
  localparam logic [DUTY_BITS-1:0] PHASE_LAST = DUTY_BITS'((1 << DUTY_BITS) - 2);

  logic                 step_tick;
  logic [DUTY_BITS-1:0] phase;
  logic [DUTY_BITS-1:0] phase_next;
  logic                 wrap;
  logic [WIDTH-1:0]     pending;

  tick_divider #(
    .TICKS (TICKS_PER_STEP)
  ) u_tick_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (step_tick)
  );

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wrap       = 1'b0;
    phase_next = phase;
    if (step_tick) begin
      wrap       = (phase == PHASE_LAST);
      phase_next = wrap ? '0 : phase + DUTY_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase        <= '0;
      period_start <= 1'b0;
    end else begin
      phase        <= phase_next;
      period_start <= wrap;
    end
  end

  // Out-of-range channels match no entry and therefore always see ready.
  always_comb begin
    wr_ready = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (wr_channel == CH_BITS'(i)) begin
        wr_ready = ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    logic [DUTY_BITS-1:0] shadow_q;
    logic [DUTY_BITS-1:0] active_q;
    logic [DUTY_BITS-1:0] active_next;
    logic                 pending_q;
    logic                 accept;
    logic                 commit;
    logic                 out_q;

    // accept needs !pending_q and commit needs pending_q, so a write landing
    // on the boundary edge waits for the following boundary.
    assign accept      = wr_valid && (wr_channel == CH_BITS'(g)) && !pending_q;
    assign commit      = wrap && pending_q;
    assign active_next = commit ? shadow_q : active_q;

    // NOTE: the per-channel duty registers are reset as well, because a
    // reset must discard pending writes and force every output low at once.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_q  <= '0;
        active_q  <= '0;
        pending_q <= 1'b0;
        out_q     <= 1'b0;
      end else begin
        if (commit) begin
          active_q  <= shadow_q;
          pending_q <= 1'b0;
        end else if (accept) begin
          shadow_q  <= wr_duty;
          pending_q <= 1'b1;
        end
        // Compare against post-edge phase/duty so out never lags a step.
        if (step_tick) begin
          out_q <= (phase_next < active_next);
        end
      end
    end

    assign pending[g] = pending_q;
    assign out[g]     = out_q;
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomized scoreboard bench for led_pwm_driver; the reference model derives
// phase and committed duty from edge counts and the list of accepted writes.
module tb_led_pwm_driver;

  // Three channels so that channel index 3 is a genuinely out-of-range select.
  localparam int WIDTH     = 3;
  localparam int DUTY_BITS = 3;
  localparam int TICKS     = 2;
  localparam int CH_BITS   = 2;
  localparam int PERIOD    = (1 << DUTY_BITS) - 1;
  localparam int BND       = TICKS * PERIOD;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [CH_BITS-1:0]   wr_channel;
  logic [DUTY_BITS-1:0] wr_duty;
  logic [WIDTH-1:0]     out;
  logic                 period_start;

  led_pwm_driver #(
    .WIDTH          (WIDTH),
    .DUTY_BITS      (DUTY_BITS),
    .TICKS_PER_STEP (TICKS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_channel   (wr_channel),
    .wr_duty      (wr_duty),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int ka;
    int duty;
  } rec_t;

  typedef struct {
    logic [WIDTH-1:0] outs;
    logic             ps;
  } exp_t;

  rec_t recs[$];
  exp_t exp_q[$];
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  // A write accepted at edge ka takes effect at the first boundary strictly after it.
  function automatic int next_boundary(input int ka);
    return (ka / BND + 1) * BND;
  endfunction

  function automatic bit model_ready(input int ch, input int k);
    if (ch >= WIDTH) return 1'b1;
    foreach (recs[i]) begin
      if (recs[i].ch == ch && recs[i].ka < k && k <= next_boundary(recs[i].ka)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int active_duty(input int ch, input int k);
    int d = 0;
    foreach (recs[i]) begin
      if (recs[i].ch == ch && next_boundary(recs[i].ka) <= k) d = recs[i].duty;
    end
    return d;
  endfunction

  // Reference model: expected state after each rising edge since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_n = 0;
      recs.delete();
      exp_q.delete();
    end else begin
      exp_t e;
      int   steps;
      int   ph;
      edge_n++;
      steps = edge_n / TICKS;
      ph    = steps % PERIOD;
      e.ps  = (edge_n % TICKS == 0) && (steps > 0) && (ph == 0);
      for (int c = 0; c < WIDTH; c++) e.outs[c] = (ph < active_duty(c, edge_n));
      exp_q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("out", 32'(out), 32'(e.outs));
      check("period_start", 32'(period_start), 32'(e.ps));
    end
  end

  task automatic drive_cycle(input bit v, input int ch, input int duty, output bit acc);
    bit rdy;
    wr_valid   = v;
    wr_channel = CH_BITS'(ch);
    wr_duty    = DUTY_BITS'(duty);
    #1;
    rdy = model_ready(ch, edge_n + 1);
    check("wr_ready", 32'(wr_ready), 32'(rdy));
    acc = v && rdy;
    if (acc && ch < WIDTH) recs.push_back('{ch: ch, ka: edge_n + 1, duty: duty});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive_cycle(1'b0, 0, 0, acc);
  endtask

  task automatic do_write(input int ch, input int duty);
    bit acc;
    int n = 0;
    do begin
      drive_cycle(1'b1, ch, duty, acc);
      n++;
    end while (!acc && n < 100);
    wr_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL write_timeout: ch %0d not accepted after %0d cycles", ch, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    reset_n    = 1'b1;
    wr_valid   = 1'b0;
    wr_channel = '0;
    wr_duty    = '0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_period_start", 32'(period_start), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle: outputs low, period_start every BND clks.
    idle(30);

    // Back-to-back writes to different channels.
    do_write(0, 3);
    do_write(1, 7);
    idle(32);

    // Second write to a pending channel stalls until the boundary.
    do_write(0, 5);
    do_write(0, 2);
    idle(32);

    // Write to a non-pending channel exactly on the boundary edge.
    n = 0;
    while ((edge_n + 1) % BND != 0 && n < 2 * BND) begin
      idle(1);
      n++;
    end
    drive_cycle(1'b1, 1, 4, acc);
    wr_valid = 1'b0;
    idle(32);

    // Out-of-range channel: accepted, no effect.
    drive_cycle(1'b1, 3, 6, acc);
    wr_valid = 1'b0;
    idle(16);

    // Randomized traffic over all channel selects.
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), acc);
    end
    wr_valid = 1'b0;
    idle(32);

    // Reset mid-period with ch0 active at 6 and a pending write.
    do_write(0, 6);
    idle(32);
    n = 0;
    while (edge_n % BND != 2 && n < 2 * BND) begin
      idle(1);
      n++;
    end
    do_write(0, 1);
    idle(3);
    check("pre_reset_out0", 32'(out[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out", 32'(out), 32'd0);
    check("async_reset_period_start", 32'(period_start), 32'd0);
    check("async_reset_wr_ready", 32'(wr_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("held_reset_out", 32'(out), 32'd0);
    reset_n = 1'b1;
    idle(40);

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
